// File: rtl/elm_pkg.sv
// Shared definitions for the neuron controllers: the sequencer state encoding
// and the elaboration-time legality check on the per-neuron weight count.
package elm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } elm_state_t;

  // A neuron needs at least one weight and cannot address more words than
  // the address width can reach.
  function automatic bit num_weight_legal(input int unsigned num_weight,
                                          input int unsigned address_width);
    return (num_weight >= 32'd1) && (num_weight <= (32'd1 << address_width));
  endfunction

endpackage

// File: rtl/pair_align_reg.sv
// One-deep valid+data register: delays an accepted input word by one cycle so
// it lines up with the weight returned by the one-cycle-latency memory.
module pair_align_reg #(
  parameter int dataWidth = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 load,
  input  logic [dataWidth-1:0] d,
  output logic                 valid,
  output logic [dataWidth-1:0] q
);

  // The data word is held between loads; only the valid bit tracks gaps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (clr) begin
      valid <= 1'b0;
    end else begin
      valid <= load;
      if (load) begin
        q <= d;
      end
    end
  end

endmodule

// File: rtl/weight_read_sequencer.sv
// Per-neuron weight read sequencer: pairs each accepted layer input with the
// weight at the matching address and hands the aligned pair to the MAC.
//
// Handshake: a word transfers on a rising edge where in_valid & in_ready are
// both high. in_ready depends only on state and clr, never on in_valid. The
// MAC side has no ready; every mac_valid cycle must be consumed.
module weight_read_sequencer
  import elm_pkg::*;
#(
  parameter int addressWidth = 10,
  parameter int dataWidth    = 16,
  parameter int numWeight    = 784
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    in_valid,
  input  logic [dataWidth-1:0]    in_data,
  output logic                    in_ready,
  output logic                    mem_ren,
  output logic [addressWidth:0]   mem_raddr,
  input  logic [dataWidth-1:0]    mem_rdata,
  output logic                    mac_valid,
  output logic [dataWidth-1:0]    mac_x,
  output logic [dataWidth-1:0]    mac_w,
  output logic                    mac_last,
  output logic                    done,
  output logic                    busy,
  output elm_state_t              dbg_state
);

  if (!num_weight_legal(numWeight, addressWidth)) begin : g_bad_num_weight
    $error("weight_read_sequencer: numWeight outside 1..2**addressWidth");
  end

  localparam logic [addressWidth:0] LAST_ADDR = (addressWidth + 1)'(numWeight - 1);

  elm_state_t              state;
  elm_state_t              state_nxt;
  logic [addressWidth:0]   addr_cnt;
  logic [addressWidth:0]   addr_nxt;
  logic                    accepting_state;
  logic                    accept;
  logic                    at_last;

  assign accepting_state = (state == IDLE) || (state == RUN);
  // clr drops any offered word, so it must also withdraw ready.
  assign in_ready        = accepting_state && !clr;
  assign accept          = in_valid && in_ready;
  assign at_last         = (addr_cnt == LAST_ADDR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      addr_cnt <= '0;
    end else begin
      state    <= state_nxt;
      addr_cnt <= addr_nxt;
    end
  end

  // The final accept leaves addr_cnt at numWeight-1 so it never wraps; the
  // DONE cycle clears it ready for the next vector.
  always_comb begin
    state_nxt = state;
    addr_nxt  = addr_cnt;
    if (clr) begin
      state_nxt = IDLE;
      addr_nxt  = '0;
    end else begin
      unique case (state)
        IDLE, RUN: begin
          if (accept) begin
            if (at_last) begin
              state_nxt = FLUSH;
            end else begin
              state_nxt = RUN;
              addr_nxt  = addr_cnt + 1'b1;
            end
          end
        end
        FLUSH: begin
          state_nxt = DONE;
        end
        DONE: begin
          state_nxt = IDLE;
          addr_nxt  = '0;
        end
        default: begin
          state_nxt = IDLE;
          addr_nxt  = '0;
        end
      endcase
    end
  end

  pair_align_reg #(
    .dataWidth (dataWidth)
  ) u_pair_align (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .load  (accept),
    .d     (in_data),
    .valid (mac_valid),
    .q     (mac_x)
  );

  assign mem_ren   = accept;
  assign mem_raddr = addr_cnt;
  assign mac_w     = mem_rdata;
  // Only the final pair of a vector is presented while in FLUSH.
  assign mac_last  = mac_valid && (state == FLUSH);
  assign done      = (state == DONE);
  assign busy      = (state != IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_weight_read_sequencer.sv
// Bench for weight_read_sequencer: two instances (4 weights and 1 weight)
// driven with directed steps then random traffic, checked against a
// transaction-level model of the vector/pair behaviour.
module tb_weight_read_sequencer;
  import elm_pkg::*;

  localparam int AW  = 10;
  localparam int DW  = 16;
  localparam int NI  = 2;
  localparam int MEM = 2 ** (AW + 1);

  // clock/reset block
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic          clr       [NI];
  logic          in_valid  [NI];
  logic [DW-1:0] in_data   [NI];
  logic          in_ready  [NI];
  logic          mem_ren   [NI];
  logic [AW:0]   mem_raddr [NI];
  logic [DW-1:0] mem_rdata [NI];
  logic          mac_valid [NI];
  logic [DW-1:0] mac_x     [NI];
  logic [DW-1:0] mac_w     [NI];
  logic          mac_last  [NI];
  logic          done      [NI];
  logic          busy      [NI];
  elm_state_t    dbg_state [NI];

  logic [DW-1:0] mem_words [NI][MEM];

  weight_read_sequencer #(.addressWidth(AW), .dataWidth(DW), .numWeight(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .clr(clr[0]), .in_valid(in_valid[0]), .in_data(in_data[0]),
    .in_ready(in_ready[0]), .mem_ren(mem_ren[0]), .mem_raddr(mem_raddr[0]),
    .mem_rdata(mem_rdata[0]), .mac_valid(mac_valid[0]), .mac_x(mac_x[0]), .mac_w(mac_w[0]),
    .mac_last(mac_last[0]), .done(done[0]), .busy(busy[0]), .dbg_state(dbg_state[0])
  );

  weight_read_sequencer #(.addressWidth(AW), .dataWidth(DW), .numWeight(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .clr(clr[1]), .in_valid(in_valid[1]), .in_data(in_data[1]),
    .in_ready(in_ready[1]), .mem_ren(mem_ren[1]), .mem_raddr(mem_raddr[1]),
    .mem_rdata(mem_rdata[1]), .mac_valid(mac_valid[1]), .mac_x(mac_x[1]), .mac_w(mac_w[1]),
    .mac_last(mac_last[1]), .done(done[1]), .busy(busy[1]), .dbg_state(dbg_state[1])
  );

  // Weight memories with one-cycle read latency
  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (mem_ren[i]) mem_rdata[i] <= mem_words[i][mem_raddr[i]];
    end
  end

  // Reference model: counts accepts per vector and the dead cycles after it
  int            m_cnt   [NI];
  int            m_dead  [NI];
  int            m_raddr [NI];
  bit            m_pv    [NI];
  bit            m_pl    [NI];
  logic [DW-1:0] m_px    [NI];
  int            m_pa    [NI];
  bit            m_acc   [NI];

  int checks = 0;
  int errors = 0;

  function automatic int nw(input int i);
    return (i == 0) ? 4 : 1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear(input int i);
    m_cnt[i] = 0; m_dead[i] = 0; m_raddr[i] = 0;
    m_pv[i] = 1'b0; m_pl[i] = 1'b0; m_pa[i] = 0;
  endtask

  task automatic check_all();
    bit exp_ready;
    for (int i = 0; i < NI; i++) begin
      exp_ready = !clr[i] && (m_dead[i] == 0);
      m_acc[i]  = in_valid[i] && exp_ready && rst_n;
      chk($sformatf("u%0d.in_ready", i),  32'(in_ready[i]),  32'(exp_ready));
      chk($sformatf("u%0d.mem_ren", i),   32'(mem_ren[i]),   32'(m_acc[i]));
      chk($sformatf("u%0d.mem_raddr", i), 32'(mem_raddr[i]), 32'(m_raddr[i]));
      chk($sformatf("u%0d.mac_valid", i), 32'(mac_valid[i]), 32'(m_pv[i]));
      chk($sformatf("u%0d.mac_last", i),  32'(mac_last[i]),  32'(m_pv[i] && m_pl[i]));
      if (m_pv[i]) begin
        chk($sformatf("u%0d.mac_x", i), 32'(mac_x[i]), 32'(m_px[i]));
        chk($sformatf("u%0d.mac_w", i), 32'(mac_w[i]), 32'(mem_words[i][m_pa[i]]));
      end
      chk($sformatf("u%0d.done", i), 32'(done[i]), 32'(m_dead[i] == 1));
      chk($sformatf("u%0d.busy", i), 32'(busy[i]), 32'((m_cnt[i] > 0) || (m_dead[i] > 0)));
    end
  endtask

  task automatic model_update();
    for (int i = 0; i < NI; i++) begin
      if (!rst_n || clr[i]) begin
        model_clear(i);
      end else begin
        m_pv[i] = m_acc[i];
        m_pl[i] = m_acc[i] && (m_cnt[i] == nw(i) - 1);
        m_pa[i] = m_raddr[i];
        if (m_acc[i]) m_px[i] = in_data[i];
        if (m_acc[i]) begin
          if (m_cnt[i] == nw(i) - 1) begin
            m_cnt[i]  = 0;
            m_dead[i] = 2;
          end else begin
            m_cnt[i]++;
            m_raddr[i]++;
          end
        end else if (m_dead[i] > 0) begin
          m_dead[i]--;
          if (m_dead[i] == 0) m_raddr[i] = 0;
        end
      end
    end
  endtask

  // driver tasks: inputs change just after the falling edge
  task automatic drive(input int i, input bit v, input logic [DW-1:0] d, input bit c);
    in_valid[i] = v;
    in_data[i]  = d;
    clr[i]      = c;
  endtask

  task automatic cycle();
    #1;
    check_all();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  bit pat [6];

  initial begin
    for (int i = 0; i < NI; i++) begin
      for (int a = 0; a < MEM; a++) mem_words[i][a] = DW'($urandom_range(0, 16'hffff));
      model_clear(i);
      drive(i, 1'b0, '0, 1'b0);
    end
    rst_n = 1'b0;
    @(negedge clk);
    cycle();
    cycle();
    rst_n = 1'b1;
    cycle();

    // held valid, inputs 1..4; single-weight neuron takes one word
    for (int k = 0; k < 8; k++) begin
      drive(0, k < 4, DW'(k + 1), 1'b0);
      drive(1, k == 0, 16'h0009, 1'b0);
      cycle();
    end

    // gapped valid pattern 1,0,1,1,0,1
    pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    for (int k = 0; k < 10; k++) begin
      drive(0, (k < 6) ? pat[k] : 1'b0, DW'(16'h0010 + k), 1'b0);
      drive(1, 1'b0, '0, 1'b0);
      cycle();
    end

    // back-to-back vectors with valid held
    for (int k = 0; k < 14; k++) begin
      drive(0, 1'b1, DW'($urandom_range(0, 16'hffff)), 1'b0);
      drive(1, 1'b1, DW'($urandom_range(0, 16'hffff)), 1'b0);
      cycle();
    end
    for (int k = 0; k < 4; k++) begin
      drive(0, 1'b0, '0, 1'b0);
      drive(1, 1'b0, '0, 1'b0);
      cycle();
    end

    // abort after two accepts, offered word during clr is dropped
    for (int k = 0; k < 12; k++) begin
      drive(0, (k != 3) && (k < 7), DW'(16'h0100 + k), k == 2);
      drive(1, 1'b0, '0, 1'b0);
      cycle();
    end

    // asynchronous reset mid-vector
    for (int k = 0; k < 2; k++) begin
      drive(0, 1'b1, DW'(16'h0200 + k), 1'b0);
      drive(1, 1'b0, '0, 1'b0);
      cycle();
    end
    drive(0, 1'b0, '0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst.in_ready",  32'(in_ready[0]),  32'd1);
    chk("rst.mem_ren",   32'(mem_ren[0]),   32'd0);
    chk("rst.mem_raddr", 32'(mem_raddr[0]), 32'd0);
    chk("rst.mac_valid", 32'(mac_valid[0]), 32'd0);
    chk("rst.mac_x",     32'(mac_x[0]),     32'd0);
    chk("rst.mac_last",  32'(mac_last[0]),  32'd0);
    chk("rst.done",      32'(done[0]),      32'd0);
    chk("rst.busy",      32'(busy[0]),      32'd0);
    for (int i = 0; i < NI; i++) model_clear(i);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      drive(0, k < 4, DW'(16'h0300 + k), 1'b0);
      drive(1, k == 1, 16'h0042, 1'b0);
      cycle();
    end

    // random traffic with occasional aborts
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < NI; i++) begin
        drive(i, $urandom_range(0, 9) < 7, DW'($urandom_range(0, 16'hffff)),
              $urandom_range(0, 49) == 0);
      end
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
